// File: rtl/popcount_acc_pkg.sv
// Shared types for the popcount accumulator: frame FSM state encoding.
package popcount_acc_pkg;

    typedef enum logic {
        ACC  = 1'b0,
        HOLD = 1'b1
    } acc_state_e;

endpackage

// File: rtl/popcount_acc_popcount.sv
// Combinational population count of one input beat.
module popcount
    import popcount_acc_pkg::*;
#(
    parameter int unsigned INPUT_WIDTH  = 64,
    parameter int unsigned OUTPUT_WIDTH = $clog2(INPUT_WIDTH) + 1
) (
    input  logic [INPUT_WIDTH-1:0]  data_i,
    output logic [OUTPUT_WIDTH-1:0] count_o
);

    always_comb begin
        count_o = '0;
        for (int unsigned i = 0; i < INPUT_WIDTH; i++) begin
            count_o = count_o + OUTPUT_WIDTH'(data_i[i]);
        end
    end

endmodule

// File: rtl/popcount_acc.sv
// Frame popcount accumulator: one registered counting stage (S1) feeding an
// ACC/HOLD accumulator that presents per-frame totals with a valid/ready handshake.
module popcount_acc
    import popcount_acc_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 64,
    parameter int unsigned MAX_BEATS  = 256
) (
    input  logic                                       clk_i,
    input  logic                                       rst_i,
    input  logic                                       valid_i,
    output logic                                       ready_o,
    input  logic [DATA_WIDTH-1:0]                      data_i,
    input  logic                                       last_i,
    output logic                                       valid_o,
    input  logic                                       ready_i,
    output logic [$clog2(DATA_WIDTH*MAX_BEATS):0]      sum_o,
    output logic [$clog2(MAX_BEATS):0]                 beats_o,
    output logic                                       overflow_o
);

    localparam int unsigned CntW  = $clog2(DATA_WIDTH) + 1;
    localparam int unsigned BeatW = $clog2(MAX_BEATS) + 1;
    localparam int unsigned AccW  = $clog2(DATA_WIDTH * MAX_BEATS) + 1;

    localparam logic [BeatW-1:0] MaxBeatsW = BeatW'(MAX_BEATS);

    acc_state_e       state_q, state_d;

    logic [CntW-1:0]  pop_cnt;
    logic             s1_valid_q;
    logic             s1_last_q;
    logic [CntW-1:0]  s1_cnt_q;

    logic [AccW-1:0]  sum_q;
    logic [BeatW-1:0] beats_q;
    logic             overflow_q;

    logic             consume;
    logic             result_hs;

    popcount #(
        .INPUT_WIDTH  (DATA_WIDTH),
        .OUTPUT_WIDTH (CntW)
    ) u_popcount (
        .data_i  (data_i),
        .count_o (pop_cnt)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ACC;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ACC:  if (s1_valid_q && s1_last_q) state_d = HOLD;
            HOLD: if (ready_i)                 state_d = ACC;
        endcase
    end

    always_comb begin
        valid_o   = (state_q == HOLD);
        consume   = s1_valid_q && (state_q == ACC);
        ready_o   = !s1_valid_q || consume;
        result_hs = valid_o && ready_i;
    end

    // S1 refills in the same cycle it drains, giving one beat per cycle in ACC.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            s1_valid_q <= 1'b0;
            s1_last_q  <= 1'b0;
            s1_cnt_q   <= '0;
        end else if (valid_i && ready_o) begin
            s1_valid_q <= 1'b1;
            s1_last_q  <= last_i;
            s1_cnt_q   <= pop_cnt;
        end else if (consume) begin
            s1_valid_q <= 1'b0;
        end
    end

    // A beat beyond MAX_BEATS only flags overflow; totals freeze at the cap.
    always_ff @(posedge clk_i) begin
        if (rst_i || result_hs) begin
            sum_q      <= '0;
            beats_q    <= '0;
            overflow_q <= 1'b0;
        end else if (consume) begin
            if (beats_q == MaxBeatsW) begin
                overflow_q <= 1'b1;
            end else begin
                sum_q   <= sum_q + AccW'(s1_cnt_q);
                beats_q <= beats_q + 1'b1;
            end
        end
    end

    assign sum_o      = sum_q;
    assign beats_o    = beats_q;
    assign overflow_o = overflow_q;

endmodule
